traffic_light_monitor: RTL

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/tlm_pkg.sv | 23 ++
 rtl/tlm_lamp_tracker.sv | 71 +++++++
 rtl/traffic_light_monitor.sv | 91 +++++++++
 3 files changed

// File: rtl/tlm_pkg.sv
// rtl/tlm_pkg.sv - lamp encodings, colour enumeration and road compatibility mask
package tlm_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    RED    = LAMP_RED,
    YELLOW = LAMP_YELLOW,
    GREEN  = LAMP_GREEN
  } colour_t;

  localparam int NUM_ROADS = 4;

  // Bit (i*4+j) set when roads i and j may be non-red together: {M1,M2} and {M1,M4}.
  localparam logic [15:0] COMPAT_MASK = 16'h101A;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == LAMP_RED) || (code == LAMP_YELLOW) || (code == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/tlm_lamp_tracker.sv
// rtl/tlm_lamp_tracker.sv - per-road colour history with sequence, illegal and dwell detection
// Dwell counting and checking exist only when TLM_DWELL_CHECK_EN is defined.
module tlm_lamp_tracker
  import tlm_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       illegal,
  output logic       seq_err,
  output logic       dwell_err,
  output logic       non_red,
  output logic       yel_to_red
);

  colour_t prev;
  colour_t cur;
  logic    legal;

  always_comb begin
    legal      = is_legal(light);
    cur        = colour_t'(light);
    illegal    = !legal;
    seq_err    = legal && (((prev == RED)    && (cur == YELLOW)) ||
                           ((prev == GREEN)  && (cur == RED))    ||
                           ((prev == YELLOW) && (cur == GREEN)));
    non_red    = legal && (cur != RED);
    yel_to_red = legal && (prev == YELLOW) && (cur == RED);
  end

`ifdef TLM_DWELL_CHECK_EN
  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_Y = 8'(MIN_YELLOW);

  logic [7:0] dwell;

  // An illegal sample leaves both history and dwell untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= RED;
      dwell <= 8'd0;
    end else if (legal) begin
      prev <= cur;
      if (cur != prev)
        dwell <= 8'd1;
      else if (dwell != 8'hFF)
        dwell <= dwell + 8'd1;
    end
  end

  assign dwell_err = legal && (cur != prev) &&
                     (((prev == GREEN)  && (dwell < MIN_G)) ||
                      ((prev == YELLOW) && (dwell < MIN_Y)));
`else
  logic unused_params;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev <= RED;
    else if (legal)
      prev <= cur;
  end

  assign dwell_err     = 1'b0;
  assign unused_params = (MIN_GREEN != 0) ^ (MIN_YELLOW != 0);
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - four-road lamp monitor with sticky error flags and rotation count
// Dwell checking is enabled by defining TLM_DWELL_CHECK_EN.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       lightM1,
  input  logic [2:0]       lightM2,
  input  logic [2:0]       lightM3,
  input  logic [2:0]       lightM4,
  input  logic             clr_err,
  output logic             err_illegal,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic [3:0]       fault_road,
  output logic [CNT_W-1:0] rotations
);

  logic [2:0] light [NUM_ROADS];
  logic [3:0] illegal, seq_err, dwell_err, non_red, yel_to_red;
  logic [3:0] conf_fault, new_fault;
  logic       conflict;
  logic       unused_yr;

  assign light[0] = lightM1;
  assign light[1] = lightM2;
  assign light[2] = lightM3;
  assign light[3] = lightM4;

  for (genvar g = 0; g < NUM_ROADS; g++) begin : g_road
    tlm_lamp_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .light     (light[g]),
      .illegal   (illegal[g]),
      .seq_err   (seq_err[g]),
      .dwell_err (dwell_err[g]),
      .non_red   (non_red[g]),
      .yel_to_red(yel_to_red[g])
    );
  end

  // Only M3 closing its yellow marks the end of a rotation.
  assign unused_yr = ^{yel_to_red[3], yel_to_red[1:0]};

  always_comb begin
    conflict   = 1'b0;
    conf_fault = 4'b0000;
    for (int i = 0; i < NUM_ROADS; i++) begin
      for (int j = i + 1; j < NUM_ROADS; j++) begin
        if (!COMPAT_MASK[4'(i * NUM_ROADS + j)] && non_red[2'(i)] && non_red[2'(j)]) begin
          conflict          = 1'b1;
          conf_fault[2'(i)] = 1'b1;
          conf_fault[2'(j)] = 1'b1;
        end
      end
    end
  end

  assign new_fault = illegal | seq_err | dwell_err | conf_fault;

  // clr_err drops old state while fresh errors in the same cycle still land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal  <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_dwell    <= 1'b0;
      fault_road   <= 4'b0000;
      rotations    <= '0;
    end else begin
      err_illegal  <= (err_illegal  & ~clr_err) | (|illegal);
      err_conflict <= (err_conflict & ~clr_err) | conflict;
      err_sequence <= (err_sequence & ~clr_err) | (|seq_err);
      err_dwell    <= (err_dwell    & ~clr_err) | (|dwell_err);
      fault_road   <= (fault_road & {4{~clr_err}}) | new_fault;
      if (yel_to_red[2])
        rotations <= rotations + CNT_W'(1);
    end
  end

endmodule
